hybrid_noc_lut_conf_ctrl: RTL and testbench

//  Per-router slot-table configuration sequencer. Receives configuration packets

---
 rtl/hybrid_noc_lut_conf_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hybrid_noc_lut_conf_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_noc_lut_conf_ctrl.sv
// Slot-table configuration sequencer: turns control packets into LUT write strobes
// on the shared lut_conf_* bus, including a full-table CLEAR sweep.
module hybrid_noc_lut_conf_ctrl #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned PORTS      = 5,
  parameter int unsigned LUT_SIZE   = 16,
  localparam int unsigned SLOT_W    = $clog2(LUT_SIZE),
  localparam int unsigned SEL_W     = $clog2(PORTS),
  localparam int unsigned DATA_W    = $clog2(PORTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     lut_conf_data,
  output logic [SEL_W-1:0]      lut_conf_sel,
  output logic [SLOT_W-1:0]     lut_conf_slot,
  output logic                  lut_conf_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  error_clr
);

  localparam int unsigned CNT_W = SLOT_W + SEL_W + 1;
  localparam logic [CNT_W-1:0]  SweepEnd = CNT_W'(PORTS * LUT_SIZE);
  localparam logic [SEL_W:0]    NumPorts = (SEL_W + 1)'(PORTS);
  localparam logic [DATA_W-1:0] MaxData  = DATA_W'(PORTS);

  typedef enum logic [1:0] {StIdle, StWrite, StClear, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                clr_last_q, clr_last_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;

  logic                accept;
  logic [1:0]          cmd;
  logic [SLOT_W-1:0]   pl_slot;
  logic [SEL_W-1:0]    pl_sel;
  logic [DATA_W-1:0]   pl_data;
  logic                pl_ok;
  logic                err_set;
  logic                unused_flit;

  assign accept      = in_valid & in_ready_q;
  assign cmd         = in_flit[1:0];
  assign pl_slot     = in_flit[SLOT_W-1:0];
  assign pl_sel      = in_flit[SLOT_W +: SEL_W];
  assign pl_data     = in_flit[SLOT_W+SEL_W +: DATA_W];
  assign pl_ok       = ({1'b0, pl_sel} < NumPorts) && (pl_data <= MaxData);
  assign unused_flit = ^in_flit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_last_d = clr_last_q;
    data_d     = data_q;
    sel_d      = sel_q;
    slot_d     = slot_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    err_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd == 2'd0) begin
            if (in_last) done_d = 1'b1;
            else         state_d = StWrite;
          end else if (cmd == 2'd1) begin
            // Entry 0 is issued straight from the header so the sweep takes
            // exactly one write per cycle while in StClear.
            sel_d      = '0;
            slot_d     = '0;
            data_d     = '1;
            valid_d    = 1'b1;
            cnt_d      = CNT_W'(1);
            clr_last_d = in_last;
            state_d    = StClear;
          end else begin
            err_set = 1'b1;
            if (in_last) done_d = 1'b1;
            else         state_d = StDrain;
          end
        end
      end
      StWrite: begin
        if (accept) begin
          if (pl_ok) begin
            sel_d   = pl_sel;
            slot_d  = pl_slot;
            data_d  = pl_data;
            valid_d = 1'b1;
          end else begin
            err_set = 1'b1;
          end
          if (in_last) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StClear: begin
        if (cnt_q == SweepEnd) begin
          done_d  = clr_last_q;
          state_d = clr_last_q ? StIdle : StDrain;
        end else begin
          sel_d   = cnt_q[SLOT_W +: SEL_W];
          slot_d  = cnt_q[SLOT_W-1:0];
          data_d  = '1;
          valid_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      StDrain: begin
        if (accept && in_last) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    error_d    = err_set | (error_q & ~error_clr);
    in_ready_d = (state_d != StClear);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_last_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sel_q      <= '0;
      slot_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_last_q <= clr_last_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      slot_q     <= slot_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign lut_conf_valid = valid_q;
  assign lut_conf_data  = data_q;
  assign lut_conf_sel   = sel_q;
  assign lut_conf_slot  = slot_q;

endmodule

// File: tb/tb_hybrid_noc_lut_conf_ctrl.sv
// Bench for hybrid_noc_lut_conf_ctrl: a packet-level schedule model checked every
// cycle, plus directed packets with hand-computed expectations.
module tb_hybrid_noc_lut_conf_ctrl;

  localparam int P = 5;
  localparam int L = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        error_clr = 1'b0;
  logic        in_ready;
  logic [2:0]  lut_conf_data;
  logic [2:0]  lut_conf_sel;
  logic [3:0]  lut_conf_slot;
  logic        lut_conf_valid, busy, done, error;

  always #5 clk = ~clk;

  hybrid_noc_lut_conf_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .in_flit        (in_flit),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .lut_conf_data  (lut_conf_data),
    .lut_conf_sel   (lut_conf_sel),
    .lut_conf_slot  (lut_conf_slot),
    .lut_conf_valid (lut_conf_valid),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .error_clr      (error_clr)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] pk(input int slot, input int sel, input int data);
    pk = {3'(data), 3'(sel), 4'(slot)};
  endfunction

  function automatic logic [31:0] pl(input int slot, input int sel, input int data);
    pl = {22'd0, pk(slot, sel, data)};
  endfunction

  function automatic logic [31:0] hdr(input int cmd);
    hdr = 32'(cmd);
  endfunction

  // Captured DUT activity for the directed literal checks.
  typedef struct {logic [9:0] w; int c; bit r;} ent_t;
  ent_t log_q[$];
  int   done_q[$];

  // Model: expected strobes/dones scheduled by absolute cycle number.
  typedef enum {MIdle, MWrite, MClear, MDrain} mmode_e;
  mmode_e     mode = MIdle;
  int         clr_end = 0;
  bit         clr_last = 1'b0;
  bit         ev_v[int];
  logic [9:0] ev_w[int];
  bit         ev_d[int];
  bit         exp_rdy = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;
  logic [9:0] last_w = '0;
  logic [9:0] cur_w;
  bit         cur_v, cur_d, acc, err_set;
  int         m_slot, m_sel, m_data;

  always @(negedge clk) begin
    if (lut_conf_valid) log_q.push_back('{{lut_conf_data, lut_conf_sel, lut_conf_slot}, cyc, in_ready});
    if (done) done_q.push_back(cyc);
    if (!rst) begin
      chk("rst_valid", lut_conf_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_error", error, 0);
      chk("rst_word", {lut_conf_data, lut_conf_sel, lut_conf_slot}, 0);
      ev_v.delete();
      ev_w.delete();
      ev_d.delete();
      mode = MIdle;
      exp_rdy = 1'b0;
      exp_busy = 1'b0;
      exp_err = 1'b0;
      last_w = '0;
    end else begin
      cur_v = ev_v.exists(cyc);
      cur_d = ev_d.exists(cyc);
      cur_w = cur_v ? ev_w[cyc] : last_w;
      chk("valid", lut_conf_valid, cur_v);
      chk("done", done, cur_d);
      chk("busy", busy, exp_busy);
      chk("in_ready", in_ready, exp_rdy);
      chk("error", error, exp_err);
      chk("conf_data", lut_conf_data, cur_w[9:7]);
      chk("conf_sel", lut_conf_sel, cur_w[6:4]);
      chk("conf_slot", lut_conf_slot, cur_w[3:0]);
      last_w = cur_w;

      err_set = 1'b0;
      acc = in_valid && exp_rdy;
      m_slot = int'(in_flit[3:0]);
      m_sel  = int'(in_flit[6:4]);
      m_data = int'(in_flit[9:7]);
      case (mode)
        MIdle: if (acc) begin
          if (in_flit[1:0] == 2'd0) begin
            if (in_last) ev_d[cyc+1] = 1'b1;
            else mode = MWrite;
          end else if (in_flit[1:0] == 2'd1) begin
            for (int k = 0; k < P * L; k++) begin
              ev_v[cyc+1+k] = 1'b1;
              ev_w[cyc+1+k] = pk(k % L, k / L, 7);
            end
            clr_end  = cyc + P * L;
            clr_last = in_last;
            mode     = MClear;
          end else begin
            err_set = 1'b1;
            if (in_last) ev_d[cyc+1] = 1'b1;
            else mode = MDrain;
          end
        end
        MWrite: if (acc) begin
          if (m_sel < P && m_data <= P) begin
            ev_v[cyc+1] = 1'b1;
            ev_w[cyc+1] = pk(m_slot, m_sel, m_data);
          end else begin
            err_set = 1'b1;
          end
          if (in_last) begin
            ev_d[cyc+1] = 1'b1;
            mode = MIdle;
          end
        end
        MClear: if (cyc == clr_end) begin
          if (clr_last) begin
            ev_d[cyc+1] = 1'b1;
            mode = MIdle;
          end else begin
            mode = MDrain;
          end
        end
        MDrain: if (acc && in_last) begin
          ev_d[cyc+1] = 1'b1;
          mode = MIdle;
        end
        default: mode = MIdle;
      endcase
      exp_err  = err_set ? 1'b1 : (error_clr ? 1'b0 : exp_err);
      exp_rdy  = (mode != MClear);
      exp_busy = (mode != MIdle);
    end
    cyc++;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge following acceptance.
  task automatic send(input logic [31:0] f, input bit last);
    int n = 0;
    in_flit  = f;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no in_ready, expected acceptance within 300 cycles");
    end
    sync();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic clear_logs();
    log_q.delete();
    done_q.delete();
  endtask

  int n_rdy;

  initial begin
    idle(3);
    @(negedge clk);
    chk("lit_rst_ready_low", in_ready, 0);
    chk("lit_rst_valid", lut_conf_valid, 0);
    sync();
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    chk("lit_ready_after_rst", in_ready, 1);
    chk("lit_busy_after_rst", busy, 0);
    chk("lit_error_after_rst", error, 0);
    sync();

    // Two-entry WRITE packet
    clear_logs();
    send(hdr(0), 0);
    send(pl(3, 1, 2), 0);
    send(pl(15, 4, 5), 1);
    idle(3);
    chk("lit_wr_count", log_q.size(), 2);
    chk("lit_wr_done_count", done_q.size(), 1);
    if (log_q.size() == 2 && done_q.size() == 1) begin
      chk("lit_wr_first", log_q[0].w, pk(3, 1, 2));
      chk("lit_wr_second", log_q[1].w, pk(15, 4, 5));
      chk("lit_wr_consecutive", log_q[1].c - log_q[0].c, 1);
      chk("lit_wr_done_with_strobe", done_q[0], log_q[1].c);
    end

    // Full CLEAR sweep, header is last
    clear_logs();
    send(hdr(1), 1);
    idle(90);
    chk("lit_clr_count", log_q.size(), P * L);
    chk("lit_clr_done_count", done_q.size(), 1);
    n_rdy = 0;
    foreach (log_q[i]) n_rdy += int'(log_q[i].r);
    chk("lit_clr_ready_low", n_rdy, 0);
    if (log_q.size() == P * L && done_q.size() == 1) begin
      chk("lit_clr_first", log_q[0].w, pk(0, 0, 7));
      chk("lit_clr_17", log_q[17].w, pk(1, 1, 7));
      chk("lit_clr_last", log_q[79].w, pk(15, 4, 7));
      chk("lit_clr_span", log_q[79].c - log_q[0].c, 79);
      chk("lit_clr_done", done_q[0], log_q[79].c + 1);
    end

    // Out-of-range entries set error and are not written
    clear_logs();
    send(hdr(0), 0);
    send(pl(2, 5, 1), 0);
    send(pl(4, 2, 6), 0);
    send(pl(7, 0, 3), 1);
    idle(2);
    chk("lit_err_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("lit_err_entry", log_q[0].w, pk(7, 0, 3));
    @(negedge clk);
    chk("lit_err_set", error, 1);
    sync();
    error_clr = 1'b1;
    sync();
    error_clr = 1'b0;
    @(negedge clk);
    chk("lit_err_cleared", error, 0);
    sync();

    // Bad command drains the rest of the packet
    clear_logs();
    send(hdr(3), 0);
    send(pl(1, 1, 1), 0);
    send(pl(2, 2, 2), 0);
    send(pl(3, 3, 3), 1);
    idle(3);
    chk("lit_bad_strobes", log_q.size(), 0);
    chk("lit_bad_done", done_q.size(), 1);
    @(negedge clk);
    chk("lit_bad_error", error, 1);
    sync();
    error_clr = 1'b1;
    sync();
    error_clr = 1'b0;

    // WRITE with sender gaps
    clear_logs();
    send(hdr(0), 0);
    idle($urandom_range(0, 3));
    send(pl(0, 0, 0), 0);
    idle($urandom_range(0, 3));
    send(pl(9, 2, 4), 0);
    idle($urandom_range(0, 3));
    send(pl(12, 3, 1), 0);
    idle($urandom_range(0, 3));
    send(pl(5, 4, 5), 1);
    idle(3);
    chk("lit_gap_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("lit_gap_0", log_q[0].w, pk(0, 0, 0));
      chk("lit_gap_1", log_q[1].w, pk(9, 2, 4));
      chk("lit_gap_2", log_q[2].w, pk(12, 3, 1));
      chk("lit_gap_3", log_q[3].w, pk(5, 4, 5));
    end

    // Reset in the middle of a CLEAR sweep
    clear_logs();
    send(hdr(1), 1);
    idle(30);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_midrst_valid", lut_conf_valid, 0);
    chk("lit_midrst_busy", busy, 0);
    chk("lit_midrst_ready", in_ready, 0);
    chk("lit_midrst_sel", lut_conf_sel, 0);
    sync();
    idle(2);
    rst = 1'b1;
    idle(3);
    chk("lit_midrst_no_done", done_q.size(), 0);
    chk("lit_midrst_partial", log_q.size(), 30);
    send(hdr(0), 0);
    send(pl(6, 3, 3), 1);
    idle(2);
    chk("lit_recover_count", log_q.size(), 31);
    if (log_q.size() == 31) chk("lit_recover_entry", log_q[30].w, pk(6, 3, 3));

    // CLEAR without last: following flits wait for the sweep, then drain
    clear_logs();
    send(hdr(1), 0);
    send(pl(1, 1, 1), 0);
    send(pl(2, 2, 2), 1);
    idle(3);
    chk("lit_clrdrain_count", log_q.size(), P * L);
    chk("lit_clrdrain_done", done_q.size(), 1);
    if (log_q.size() == P * L && done_q.size() == 1)
      chk("lit_clrdrain_done_after", done_q[0] > log_q[79].c + 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
